// File: rtl/keypad_pkg.sv
// Shared types, keymap and default parameters for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam int DEF_SCAN_DIV       = 100000;
  localparam int DEF_DEBOUNCE_SCANS = 4;
  localparam int DEF_REPEAT_SCANS   = 500;

  // Indexed by {row, col}; row 0 is the top row.
  localparam logic [15:0][3:0] KEYMAP =
    64'hDEF0_C987_B654_A321;

  function automatic logic [1:0] first_low(
    input logic [3:0] r
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!r[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-rate prescaler: one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(SCAN_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad column scanner with debounce and a valid/ready key output.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat events while a key is held.
module keypad_scan_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  parameter int REPEAT_SCANS   = DEF_REPEAT_SCANS
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  logic          tick;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  state_t        state, state_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_idx, row_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          row_low;
  logic          key_event;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rpt, rpt_n;
`endif

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign row_low  = ~row_sync[row_idx];
  assign col      = ~(4'b0001 << col_idx);
  assign key_held = (state == PRESSED) ||
                    (state == RELEASE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= SCAN;
      col_idx <= '0;
      row_idx <= '0;
      dcnt    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt     <= '0;
`endif
    end else begin
      state   <= state_n;
      col_idx <= col_n;
      row_idx <= row_n;
      dcnt    <= dcnt_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt     <= rpt_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    row_n     = row_idx;
    dcnt_n    = dcnt;
    key_event = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_n     = rpt;
`endif
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (row_sync != 4'b1111) begin
            row_n   = first_low(row_sync);
            dcnt_n  = DW'(1);
            state_n = DEBOUNCE;
          end else begin
            col_n = col_idx + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_low) begin
            state_n = SCAN;
            col_n   = col_idx + 1'b1;
          end else if (int'(dcnt) + 1 >= DEBOUNCE_SCANS) begin
            state_n   = PRESSED;
            key_event = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_n     = '0;
`endif
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!row_low) begin
            state_n = RELEASE;
            dcnt_n  = DW'(1);
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (int'(rpt) + 1 >= REPEAT_SCANS) begin
            key_event = 1'b1;
            rpt_n     = '0;
          end else begin
            rpt_n = rpt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (row_low) begin
            state_n = PRESSED;
          end else if (int'(dcnt) + 1 >= DEBOUNCE_SCANS) begin
            state_n = SCAN;
            col_n   = col_idx + 1'b1;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // A pending key being accepted this cycle frees the slot for the new one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (key_event && (!key_valid || key_ready)) begin
        key_code  <= KEYMAP[{row_idx, col_idx}];
        key_valid <= 1'b1;
      end else begin
        if (key_event)
          overrun <= 1'b1;
        if (key_valid && key_ready)
          key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Directed bench for keypad_scan_fsm with a switch-matrix keypad model.
module tb_keypad_scan_fsm;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;
  int ev_cnt = 0;
  int ovr_cnt = 0;
  int ev0;
  event tb_tick;

  keypad_scan_fsm #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS  (5)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  // Key (r,c) shorts row r low while column c is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Scan tick reference: every 4th clock after reset release.
  always @(posedge clock) begin
    if (!reset_n) begin
      phase = 0;
    end else begin
      if (phase == 3) -> tb_tick;
      phase = (phase == 3) ? 0 : phase + 1;
    end
  end

  always @(negedge clock) begin
    if (reset_n && key_valid && key_ready) ev_cnt++;
    if (reset_n && overrun) ovr_cnt++;
  end

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(tb_tick);
    #1;
  endtask

  task automatic wait_held(input logic want, input string tag);
    int n = 0;
    while (key_held !== want && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(tag, 8'(key_held), 8'(want));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_col"}, 8'(col), 8'h0e);
    check({tag, "_code"}, 8'(key_code), 8'h0);
    check({tag, "_valid"}, 8'(key_valid), 8'h0);
    check({tag, "_held"}, 8'(key_held), 8'h0);
    check({tag, "_ovr"}, 8'(overrun), 8'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    keys      = '0;
    key_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset("rst");
    reset_n = 1'b1;

    // '6' = row 1, col 2
    keys = 16'(1) << 6;
    wait_ticks(1);
    check("scan_c1", 8'(col), 8'h0d);
    wait_ticks(1);
    check("scan_c2", 8'(col), 8'h0b);
    wait_ticks(1);
    check("det_col", 8'(col), 8'h0b);
    check("det_held", 8'(key_held), 8'h0);
    wait_ticks(1);
    check("db_valid", 8'(key_valid), 8'h0);
    wait_ticks(1);
    check("k6_valid", 8'(key_valid), 8'h1);
    check("k6_held", 8'(key_held), 8'h1);
    check("k6_code", 8'(key_code), 8'h6);
    key_ready = 1'b1;
    @(posedge clock);
    #1;
    check("k6_clear", 8'(key_valid), 8'h0);
    key_ready = 1'b0;
    keys = '0;
    wait_ticks(2);
    check("rel_held", 8'(key_held), 8'h1);
    wait_ticks(1);
    check("rel_done", 8'(key_held), 8'h0);
    check("rel_col", 8'(col), 8'h07);

    // bounce on 'B' (row 1, col 3)
    keys = 16'(1) << 7;
    wait_ticks(1);
    check("bnc_hold", 8'(col), 8'h07);
    keys = '0;
    wait_ticks(1);
    check("bnc_col0", 8'(col), 8'h0e);
    check("bnc_held", 8'(key_held), 8'h0);
    wait_ticks(1);
    check("bnc_col1", 8'(col), 8'h0d);
    check("bnc_valid", 8'(key_valid), 8'h0);

    // '5' then '9' with no consumer
    keys = 16'(1) << 5;
    wait_held(1'b1, "k5_held");
    check("k5_code", 8'(key_code), 8'h5);
    check("k5_valid", 8'(key_valid), 8'h1);
    keys = '0;
    wait_held(1'b0, "k5_rel");
    keys = 16'(1) << 10;
    wait_held(1'b1, "k9_held");
    check("k9_code", 8'(key_code), 8'h5);
    check("k9_ovr", 8'(overrun), 8'h1);
    @(posedge clock);
    #1;
    check("k9_ovr_end", 8'(overrun), 8'h0);
    check("k9_valid", 8'(key_valid), 8'h1);
    key_ready = 1'b1;
    @(posedge clock);
    #1;
    check("k9_clear", 8'(key_valid), 8'h0);
    keys = '0;
    wait_held(1'b0, "k9_rel");

    // '0' and 'D' together from column 0
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ev0 = ev_cnt;
    keys = (16'(1) << 12) | (16'(1) << 15);
    wait_held(1'b1, "k0_held");
    check("k0_code", 8'(key_code), 8'h0);
    check("k0_valid", 8'(key_valid), 8'h1);
    wait_ticks(2);
    keys = '0;
    wait_held(1'b0, "k0_rel");
    check("k0_events", 8'(ev_cnt - ev0), 8'h1);

    // reset while '6' is held
    key_ready = 1'b0;
    keys = 16'(1) << 6;
    wait_held(1'b1, "mid_held");
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_reset("mid");
    reset_n = 1'b1;
    wait_held(1'b1, "redet_held");
    check("redet_code", 8'(key_code), 8'h6);
    check("redet_valid", 8'(key_valid), 8'h1);
    key_ready = 1'b1;
    keys = '0;
    wait_held(1'b0, "redet_rel");

    // hold 'A' (row 0, col 3) for 12 ticks
    ev0 = ev_cnt;
    keys = 16'(1) << 3;
    wait_held(1'b1, "kA_held");
    check("kA_code", 8'(key_code), 8'hA);
    wait_ticks(11);
    keys = '0;
    wait_held(1'b0, "kA_rel");
    repeat (2) @(posedge clock);
    #1;
`ifdef KEYPAD_AUTOREPEAT_EN
    check("kA_events", 8'(ev_cnt - ev0), 8'h3);
`else
    check("kA_events", 8'(ev_cnt - ev0), 8'h1);
`endif
    check("ovr_total", 8'(ovr_cnt), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_fsm.md
KEYPAD_SCAN_FSM -- requirements
Module: keypad_scan_fsm

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clocks per scan tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive stable ticks to accept a press or release.
REQ-003 SHALL have parameter REPEAT_SCANS, default 500, ticks between auto-repeat events.
REQ-004 Ports, clock and reset first:
- clock  in  1  system clock, single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- row  in  4  keypad row lines, active-low, asynchronous to clock.
- col  out  4  keypad column drive, active-low, one-hot-low.
- key_code  out  4  hex value of the accepted key.
- key_valid  out  1  key_code is valid.
- key_ready  in  1  consumer accepts key_code.
- key_held  out  1  a key is currently down.
- overrun  out  1  one-cycle pulse when a key event is dropped.

Function
REQ-005 SHALL pass row through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-006 SHALL generate a one-cycle tick when the prescaler reaches SCAN_DIV-1, then wrap it to 0.
REQ-007 SHALL drive exactly one col bit low at all times; column c corresponds to col[c]=0.
REQ-008 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE; all transitions SHALL occur only on tick.
REQ-009 SCAN on tick: if any synchronized row bit is low, SHALL latch the lowest such row index r and the current column c, hold col, set the debounce count to 1, and enter DEBOUNCE; otherwise SHALL advance the column 0->1->2->3->0.
REQ-010 DEBOUNCE on tick: if row r is low, SHALL increment the count, and on reaching DEBOUNCE_SCANS SHALL enter PRESSED; if row r is high, SHALL return to SCAN and advance the column.
REQ-011 Key mapping, rows top to bottom by columns 0..3:
- r0: 1,2,3,A
- r1: 4,5,6,B
- r2: 7,8,9,C
- r3: 0,F,E,D
REQ-012 On entry to PRESSED: if key_valid is 0, SHALL load key_code and set key_valid one cycle after the tick; if key_valid is 1, SHALL keep the old key_code and pulse overrun.
REQ-013 key_valid SHALL remain high until a cycle with key_valid&&key_ready; it SHALL clear on the following cycle.
REQ-014 Simultaneous load and accept in the same cycle SHALL accept the old code and load the new one, with key_valid staying high and no overrun.
REQ-015 PRESSED on tick with row r high SHALL enter RELEASE with count 1; other rows and columns SHALL be ignored while a key is latched.
REQ-016 RELEASE on tick:
- row r low: SHALL return to PRESSED without a new key event.
- row r high: SHALL increment the count; at DEBOUNCE_SCANS SHALL enter SCAN and advance the column.
REQ-017 key_held SHALL be 1 exactly in PRESSED and RELEASE.
REQ-018 Scan-to-valid latency SHALL be DEBOUNCE_SCANS ticks plus 1 clock after the first detecting tick.

Reset
REQ-019 When reset_n=0 at a clock edge, the block SHALL reset to:
- state SCAN, column 0 (col=4'b1110).
- prescaler and counters 0.
- synchronizer 4'b1111.
- key_code 0; key_valid, key_held and overrun 0.
REQ-020 Reset mid-press SHALL discard the latched key; a still-held key SHALL be re-detected and debounced as new.

Configuration
REQ-021 Macro KEYPAD_AUTOREPEAT_EN defined: in PRESSED, every REPEAT_SCANS ticks SHALL generate a key event under REQ-012 and REQ-013; the repeat count SHALL restart on entry to PRESSED from DEBOUNCE only.
REQ-022 Macro undefined: exactly one key event per debounced press; REPEAT_SCANS SHALL be unused.

Structure
REQ-023 Package keypad_pkg SHALL hold the state enum, the 16-entry keymap constant, and the default parameter values.
REQ-024 Sub-module keypad_tick_gen SHALL implement the prescaler and tick output.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5)
REQ-025 Hold row[1] low while col[2]=0 -> key_code=4'h6, key_valid after 3 ticks +1 clk, key_held=1.
REQ-026 Bounce row low 1 tick, high 1 tick -> no key_valid; column resumes advancing.
REQ-027 key_ready=0, two separate presses '5' then '9' -> key_code stays 5 and overrun pulses once; key_ready=1 -> key_valid clears the next cycle.
REQ-028 Press '0' and 'D' together (r3, c0 and c3) -> single event with key_code=0.
REQ-029 reset_n=0 for one clock during PRESSED -> all outputs at reset values and col=4'b1110; key re-detected afterwards.
REQ-030 KEYPAD_AUTOREPEAT_EN defined, hold 'A' 12 ticks with key_ready=1 -> 3 events total (initial plus 2 repeats); undefined -> 1 event.
